// File: rtl/car_frame_scheduler.sv
// car_frame_scheduler
// Per-frame sequencer for the car sprite engines. On each frame tick every
// car is erased at its previous position (if it has one) and then redrawn at
// its new position, one engine at a time. A watchdog aborts a stuck engine
// phase, and sticky flags report frame overruns and engine hangs.
//
// Optional feature: define CAR_SCHED_SKIP_STATIC_EN to skip cars whose
// {X,Y,Dir,Go} has not changed since they were last drawn.
module car_frame_scheduler #(
  parameter int unsigned NUM_CARS       = 2,
  parameter int unsigned TIMEOUT_CYCLES = 4095
) (
  input  logic                    iClock,
  input  logic                    iResetn,
  input  logic                    iFrameTick,
  input  logic [8*NUM_CARS-1:0]   iCarX,
  input  logic [7*NUM_CARS-1:0]   iCarY,
  input  logic [3*NUM_CARS-1:0]   iCarDir,
  input  logic [2*NUM_CARS-1:0]   iCarGo,
  output logic                    oEraseStart,
  input  logic                    iEraseDone,
  output logic                    oDrawStart,
  input  logic                    iDrawDone,
  output logic [7:0]              oX,
  output logic [6:0]              oY,
  output logic [2:0]              oDir,
  output logic [1:0]              oGo,
  output logic                    oSel,
  output logic [1:0]              oCarIdx,
  output logic                    oBusy,
  output logic                    oFrameDone,
  output logic                    oOverrun,
  output logic                    oFault
);

  typedef enum logic [2:0] {
    IDLE, LATCH, ERASE_REQ, ERASE_WAIT, DRAW_REQ, DRAW_WAIT, NEXT, DONE
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  idx, idx_nxt;
  logic [11:0] wd_cnt;
  logic        wd_hit;
  logic        skip;
  logic [3:0]  prev_valid;

  // Storage is sized for the maximum car count so a 2-bit index never
  // exceeds the array bounds; entries at or above NUM_CARS are never used.
  logic [7:0] new_x   [4];
  logic [6:0] new_y   [4];
  logic [2:0] new_dir [4];
  logic [1:0] new_go  [4];
  logic [7:0] prev_x  [4];
  logic [6:0] prev_y  [4];
  logic [2:0] prev_dir[4];
  logic [1:0] prev_go [4];

  // Next-state, next-index, watchdog expiry and static-car skip decision.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    skip      = 1'b0;
    // wd_cnt counts wait cycles already completed, so the TIMEOUT_CYCLES-th
    // wait cycle is the one where the counter reads TIMEOUT_CYCLES-1.
    wd_hit    = (wd_cnt == 12'(TIMEOUT_CYCLES - 1));
`ifdef CAR_SCHED_SKIP_STATIC_EN
    skip = prev_valid[idx] &&
           (new_x[idx]   == prev_x[idx])   && (new_y[idx]  == prev_y[idx]) &&
           (new_dir[idx] == prev_dir[idx]) && (new_go[idx] == prev_go[idx]);
`endif
    case (state)
      IDLE:       if (iFrameTick) state_nxt = LATCH;
      LATCH: begin
        idx_nxt   = '0;
        state_nxt = ERASE_REQ;
      end
      ERASE_REQ: begin
        if (skip)                 state_nxt = NEXT;
        else if (prev_valid[idx]) state_nxt = ERASE_WAIT;
        else                      state_nxt = DRAW_REQ;
      end
      ERASE_WAIT: if (iEraseDone || wd_hit) state_nxt = DRAW_REQ;
      DRAW_REQ:   state_nxt = DRAW_WAIT;
      DRAW_WAIT:  if (iDrawDone || wd_hit) state_nxt = NEXT;
      NEXT: begin
        if (idx == 2'(NUM_CARS - 1)) begin
          state_nxt = DONE;
        end else begin
          idx_nxt   = idx + 2'd1;
          state_nxt = ERASE_REQ;
        end
      end
      DONE:       state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Pulses and status decoded from the registered state.
  always_comb begin
    oEraseStart = (state == ERASE_REQ) && prev_valid[idx] && !skip;
    oDrawStart  = (state == DRAW_REQ);
    oSel        = (state == DRAW_REQ) || (state == DRAW_WAIT);
    oBusy       = (state != IDLE);
    oFrameDone  = (state == DONE);
    oCarIdx     = idx;
  end

  // Control state, watchdog, sticky flags, validity bits and engine operands.
  always_ff @(posedge iClock) begin
    if (!iResetn) begin
      state      <= IDLE;
      idx        <= '0;
      wd_cnt     <= '0;
      prev_valid <= '0;
      oOverrun   <= 1'b0;
      oFault     <= 1'b0;
      oX         <= '0;
      oY         <= '0;
      oDir       <= '0;
      oGo        <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;

      if ((state_nxt == ERASE_WAIT || state_nxt == DRAW_WAIT) && state_nxt != state)
        wd_cnt <= '0;
      else if (state == ERASE_WAIT || state == DRAW_WAIT)
        wd_cnt <= wd_cnt + 12'd1;

      if (iFrameTick && state != IDLE)
        oOverrun <= 1'b1;

      if ((state == ERASE_WAIT && !iEraseDone && wd_hit) ||
          (state == DRAW_WAIT  && !iDrawDone  && wd_hit))
        oFault <= 1'b1;

      if (state == DRAW_WAIT && iDrawDone)
        prev_valid[idx] <= 1'b1;

      // Operands are loaded on REQ entry so they are already valid during
      // the start pulse and hold through the following WAIT.
      if (state_nxt == ERASE_REQ && prev_valid[idx_nxt]) begin
        oX   <= prev_x[idx_nxt];
        oY   <= prev_y[idx_nxt];
        oDir <= prev_dir[idx_nxt];
        oGo  <= prev_go[idx_nxt];
      end else if (state_nxt == DRAW_REQ && state != DRAW_REQ) begin
        oX   <= new_x[idx];
        oY   <= new_y[idx];
        oDir <= new_dir[idx];
        oGo  <= new_go[idx];
      end
    end
  end

  // Position snapshot at frame start and prev update on a completed draw.
  always_ff @(posedge iClock) begin
    if (state == LATCH) begin
      for (int unsigned k = 0; k < NUM_CARS; k++) begin
        new_x[k]   <= iCarX[8*k +: 8];
        new_y[k]   <= iCarY[7*k +: 7];
        new_dir[k] <= iCarDir[3*k +: 3];
        new_go[k]  <= iCarGo[2*k +: 2];
      end
    end
    if (state == DRAW_WAIT && iDrawDone) begin
      prev_x[idx]   <= new_x[idx];
      prev_y[idx]   <= new_y[idx];
      prev_dir[idx] <= new_dir[idx];
      prev_go[idx]  <= new_go[idx];
    end
  end

endmodule

// File: tb/tb_car_frame_scheduler.sv
// tb_car_frame_scheduler
// Scoreboarded bench: expected engine start transactions are queued when a
// frame is launched and popped as the scheduler issues start pulses. The
// bench plays both engines, returning done pulses after chosen delays.
module tb_car_frame_scheduler;

  localparam int unsigned NC = 2;
  localparam int unsigned TO = 15;

  logic          clk = 1'b0;
  logic          rstn;
  logic          tick;
  logic [8*NC-1:0] car_x;
  logic [7*NC-1:0] car_y;
  logic [3*NC-1:0] car_dir;
  logic [2*NC-1:0] car_go;
  logic          erase_start, erase_done, draw_start, draw_done;
  logic [7:0]    x;
  logic [6:0]    y;
  logic [2:0]    dir;
  logic [1:0]    go;
  logic          sel;
  logic [1:0]    car_idx;
  logic          busy, frame_done, overrun, fault;

  always #5 clk = ~clk;

  car_frame_scheduler #(.NUM_CARS(NC), .TIMEOUT_CYCLES(TO)) dut (
    .iClock(clk), .iResetn(rstn), .iFrameTick(tick),
    .iCarX(car_x), .iCarY(car_y), .iCarDir(car_dir), .iCarGo(car_go),
    .oEraseStart(erase_start), .iEraseDone(erase_done),
    .oDrawStart(draw_start), .iDrawDone(draw_done),
    .oX(x), .oY(y), .oDir(dir), .oGo(go), .oSel(sel), .oCarIdx(car_idx),
    .oBusy(busy), .oFrameDone(frame_done), .oOverrun(overrun), .oFault(fault)
  );

  typedef struct { int draw; int car; int x; int y; int d; int g; } exp_t;
  exp_t sb[$];

  int n_pass = 0;
  int n_total = 0;

  int cx[NC], cy[NC], cd[NC], cg[NC];
  int m_valid[NC], px[NC], py[NC], pd[NC], pg[NC];
  int m_fault = 0;
  int m_ovr = 0;

  task automatic check(input string tag, input int got, input int want);
    n_total++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, want);
  endtask

  task automatic drive_cars();
    for (int k = 0; k < NC; k++) begin
      car_x[8*k +: 8]   = 8'(cx[k]);
      car_y[7*k +: 7]   = 7'(cy[k]);
      car_dir[3*k +: 3] = 3'(cd[k]);
      car_go[2*k +: 2]  = 2'(cg[k]);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NC; k++) m_valid[k] = 0;
    m_fault = 0;
    m_ovr = 0;
  endtask

  // ed: erase-done delay; dd0/dd1: draw-done delay per car (0 = withhold);
  // ovr: raise a tick during the last car's draw wait.
  task automatic run_frame(input int ed, input int dd0, input int dd1, input int ovr);
    int dd[NC];
    int cyc, wcnt, delay, pending, fin, first, fault_next, all_skipped;
    int last_erase_done, last_draw_done, pulses;
    exp_t cur;
    dd[0] = dd0;
    dd[1] = dd1;
    all_skipped = 1;
    cur = '{0, 0, 0, 0, 0, 0};
    for (int k = 0; k < NC; k++) begin
      int skipk;
      skipk = 0;
`ifdef CAR_SCHED_SKIP_STATIC_EN
      skipk = (m_valid[k] != 0) && cx[k] == px[k] && cy[k] == py[k] &&
              cd[k] == pd[k] && cg[k] == pg[k];
`endif
      if (skipk == 0) begin
        all_skipped = 0;
        if (m_valid[k] != 0) sb.push_back('{0, k, px[k], py[k], pd[k], pg[k]});
        sb.push_back('{1, k, cx[k], cy[k], cd[k], cg[k]});
      end
    end
    drive_cars();
    @(negedge clk);
    tick = 1'b1;
    cyc = 0;
    @(negedge clk);
    tick = 1'b0;
    cyc = 1;
    first = 1; pending = 0; fin = 0; fault_next = 0; wcnt = 0; delay = 0;
    last_erase_done = -1; last_draw_done = -1;
    while (fin == 0 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      erase_done = 1'b0;
      draw_done  = 1'b0;
      tick       = 1'b0;
      if (fault_next != 0) begin
        check("fault_set", fault, 1);
        fault_next = 0;
      end
      if (erase_start || draw_start) begin
        if (sb.size() == 0) begin
          check("unexpected_start", 1, 0);
        end else begin
          cur = sb.pop_front();
          check("kind", draw_start, cur.draw);
          check("car_idx", car_idx, cur.car);
          check("x", x, cur.x);
          check("y", y, cur.y);
          check("dir", dir, cur.d);
          check("go", go, cur.g);
          check("sel", sel, cur.draw);
          if (first != 0 && cur.draw == 0) check("tick_to_erase", cyc, 2);
          if (cur.draw != 0 && last_erase_done >= 0)
            check("erase_done_to_draw", cyc, last_erase_done + 1);
          pending = 1;
          wcnt = 0;
          delay = (cur.draw != 0) ? dd[cur.car] : ed;
          last_erase_done = -1;
        end
        first = 0;
        car_x = 16'($urandom); car_y = 14'($urandom);
        car_dir = 6'($urandom); car_go = 4'($urandom);
      end else if (pending != 0) begin
        wcnt++;
        check("hold_x", x, cur.x);
        check("hold_sel", sel, cur.draw);
        if (wcnt == delay) begin
          if (cur.draw != 0) begin draw_done = 1'b1; last_draw_done = cyc; end
          else begin erase_done = 1'b1; last_erase_done = cyc; end
          pending = 0;
        end else begin
          if (cur.draw != 0 && wcnt == 1) erase_done = 1'b1;
          if (ovr != 0 && cur.draw != 0 && cur.car == NC - 1 && wcnt == 1) tick = 1'b1;
          if (wcnt == TO) begin
            check("fault_pre", fault, m_fault);
            pending = 0;
            fault_next = 1;
            if (cur.draw != 0) last_draw_done = cyc;
            else last_erase_done = cyc;
          end
        end
      end
      if (frame_done) begin
        fin = 1;
        if (all_skipped != 0) check("skip_frame_latency", cyc, 2 + 2 * NC);
        else check("draw_done_to_frame_done", cyc, last_draw_done + 2);
      end
    end
    erase_done = 1'b0;
    draw_done = 1'b0;
    tick = 1'b0;
    check("frame_done_seen", fin, 1);
    check("sb_empty", sb.size(), 0);
    sb.delete();
    for (int k = 0; k < NC; k++) begin
      if (dd[k] != 0 && dd[k] <= TO) begin
        m_valid[k] = 1;
        px[k] = cx[k]; py[k] = cy[k]; pd[k] = cd[k]; pg[k] = cg[k];
      end else if (all_skipped == 0) begin
        m_fault = 1;
      end
    end
    if (ovr != 0) m_ovr = 1;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) check("busy_after_frame", busy, 0);
      pulses += int'(erase_start) + int'(draw_start) + int'(frame_done);
    end
    check("extra_pulses", pulses, 0);
    check("fault", fault, m_fault);
    check("overrun", overrun, m_ovr);
  endtask

  initial begin
    rstn = 1'b0; tick = 1'b0; erase_done = 1'b0; draw_done = 1'b0;
    car_x = '0; car_y = '0; car_dir = '0; car_go = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_erase_start", erase_start, 0);
    check("rst_draw_start", draw_start, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_sel", sel, 0);
    check("rst_x", x, 0);
    check("rst_idx", car_idx, 0);
    check("rst_overrun", overrun, 0);
    check("rst_fault", fault, 0);
    rstn = 1'b1;

    // First frame: no erases; car0 done coincides with the timeout cycle.
    cx = '{10, 50}; cy = '{20, 30}; cd = '{0, 3}; cg = '{1, 2};
    run_frame(2, TO, 3, 0);

    // Car0 moved: erase at old x=10, draw at new x=12.
    cx[0] = 12;
    run_frame(3, 2, 4, 0);

    // Overrun tick during the last car's draw wait.
    cx[1] = 60; cg[1] = 3;
    run_frame(1, 2, 3, 1);

    // Reset in the middle of a frame.
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    repeat (4) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    check("midrst_busy", busy, 0);
    check("midrst_overrun", overrun, 0);
    check("midrst_sel", sel, 0);
    model_reset();

    // Car0 draw withheld: watchdog fires, prev stays invalid.
    cx = '{30, 70}; cy = '{5, 40}; cd = '{5, 7}; cg = '{0, 1};
    run_frame(2, 0, 2, 0);

    // Car0 has no valid prev, car1 does.
    cx[1] = 72;
    run_frame(2, 3, 2, 0);

    // Identical positions repeated.
    run_frame(2, 2, 2, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
